// File: rtl/mem_line_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_line_arbiter
//  Purpose  : Memory-side line-fill / write-back responder. It serves two
//             cache clients round-robin and serialises each line into
//             BEATW-bit beats on one downstream bus.
//             Optional beat watchdog: define ARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_line_arbiter #(
    parameter int BLOCKSZ        = 512,
    parameter int BEATW          = 64,
    parameter int ADDRESSSIZE    = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   c0_req,
    input  logic                   c0_wr_en,
    input  logic [ADDRESSSIZE-1:0] c0_addr,
    input  logic [BLOCKSZ-1:0]     c0_wdata,
    output logic [BLOCKSZ-1:0]     c0_rdata,
    output logic                   c0_data_valid,
    input  logic                   c1_req,
    input  logic                   c1_wr_en,
    input  logic [ADDRESSSIZE-1:0] c1_addr,
    input  logic [BLOCKSZ-1:0]     c1_wdata,
    output logic [BLOCKSZ-1:0]     c1_rdata,
    output logic                   c1_data_valid,
    output logic                   bus_req,
    output logic                   bus_wr,
    output logic [ADDRESSSIZE-1:0] bus_addr,
    input  logic                   bus_ack,
    output logic [BEATW-1:0]       bus_wdata,
    output logic                   bus_wvalid,
    input  logic                   bus_wready,
    input  logic [BEATW-1:0]       bus_rdata,
    input  logic                   bus_rvalid,
    output logic                   err
);

    localparam int c_NBEATS = BLOCKSZ / BEATW;
    localparam int c_CNTW   = (c_NBEATS > 1) ? $clog2(c_NBEATS) : 1;
    localparam logic [c_CNTW-1:0]      c_LAST      = c_CNTW'(c_NBEATS - 1);
    localparam logic [ADDRESSSIZE-1:0] c_ADDR_MASK = ~ADDRESSSIZE'(63);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_CMD  = 3'd1;
    localparam logic [2:0] c_RD   = 3'd2;
    localparam logic [2:0] c_WR   = 3'd3;
    localparam logic [2:0] c_RESP = 3'd4;

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic                   r_pend0;
    logic                   r_pend1;
    logic                   r_wr0;
    logic                   r_wr1;
    logic [ADDRESSSIZE-1:0] r_addr0;
    logic [ADDRESSSIZE-1:0] r_addr1;
    logic [BLOCKSZ-1:0]     r_wdata0;
    logic [BLOCKSZ-1:0]     r_wdata1;
    logic                   r_gnt;
    logic                   w_gnt_nxt;
    logic                   r_last;
    logic [c_CNTW-1:0]      r_cnt;
    logic [BLOCKSZ-1:0]     r_line;
    logic                   r_to;
    logic [BLOCKSZ-1:0]     r_c0_rdata;
    logic [BLOCKSZ-1:0]     r_c1_rdata;
    logic                   r_c0_dv;
    logic                   r_c1_dv;
    logic                   r_err;

    logic                   w_cur_wr;
    logic [ADDRESSSIZE-1:0] w_cur_addr;
    logic [BLOCKSZ-1:0]     w_cur_wdata;
    logic                   w_bus_req;
    logic                   w_bus_wvalid;
    logic                   w_cnt_clr;
    logic                   w_cnt_inc;
    logic                   w_rd_we;
    logic                   w_to_hit;
    logic                   w_to_abort;

    // Operand mux for the client currently holding the grant
    assign w_cur_wr    = r_gnt ? r_wr1    : r_wr0;
    assign w_cur_addr  = r_gnt ? r_addr1  : r_addr0;
    assign w_cur_wdata = r_gnt ? r_wdata1 : r_wdata0;

`ifdef ARB_TIMEOUT_EN
    localparam int c_TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TOW-1:0] c_TO_LAST = c_TOW'(TIMEOUT_CYCLES - 1);

    logic [c_TOW-1:0] r_tcnt;
    logic             w_waiting;
    logic             w_progress;

    assign w_waiting  = (r_state == c_CMD) || (r_state == c_RD) || (r_state == c_WR);
    assign w_progress = ((r_state == c_CMD) && bus_ack)    ||
                        ((r_state == c_RD)  && bus_rvalid) ||
                        ((r_state == c_WR)  && bus_wready);
    assign w_to_hit   = w_waiting && !w_progress && (r_tcnt == c_TO_LAST);

    always_ff @(posedge clk) begin
        if (rst || !w_waiting || w_progress) begin
            r_tcnt <= '0;
        end else if (!w_to_hit) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_bus_req    = 1'b0;
        w_bus_wvalid = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_rd_we      = 1'b0;
        w_to_abort   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (r_pend0 || r_pend1) begin
                    // Contention favours the client that was not served last
                    w_gnt_nxt   = (r_pend0 && r_pend1) ? ~r_last : r_pend1;
                    w_state_nxt = c_CMD;
                end
            end
            c_CMD: begin
                w_bus_req = 1'b1;
                if (bus_ack) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = w_cur_wr ? c_WR : c_RD;
                end else if (w_to_hit) begin
                    w_to_abort  = 1'b1;
                    w_state_nxt = c_RESP;
                end
            end
            c_RD: begin
                if (bus_rvalid) begin
                    w_rd_we   = 1'b1;
                    w_cnt_inc = 1'b1;
                    if (r_cnt == c_LAST) begin
                        w_state_nxt = c_RESP;
                    end
                end else if (w_to_hit) begin
                    w_to_abort  = 1'b1;
                    w_state_nxt = c_RESP;
                end
            end
            c_WR: begin
                w_bus_wvalid = 1'b1;
                if (bus_wready) begin
                    w_cnt_inc = 1'b1;
                    if (r_cnt == c_LAST) begin
                        w_state_nxt = c_RESP;
                    end
                end else if (w_to_hit) begin
                    w_to_abort  = 1'b1;
                    w_state_nxt = c_RESP;
                end
            end
            c_RESP: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_pend0    <= 1'b0;
            r_pend1    <= 1'b0;
            r_wr0      <= 1'b0;
            r_wr1      <= 1'b0;
            r_addr0    <= '0;
            r_addr1    <= '0;
            r_wdata0   <= '0;
            r_wdata1   <= '0;
            r_gnt      <= 1'b0;
            r_last     <= 1'b0;
            r_cnt      <= '0;
            r_line     <= '0;
            r_to       <= 1'b0;
            r_c0_rdata <= '0;
            r_c1_rdata <= '0;
            r_c0_dv    <= 1'b0;
            r_c1_dv    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;

            // Pending stays set through service, so repeats are dropped until RESP
            if (c0_req && !r_pend0) begin
                r_pend0  <= 1'b1;
                r_wr0    <= c0_wr_en;
                r_addr0  <= c0_addr;
                r_wdata0 <= c0_wdata;
            end
            if (c1_req && !r_pend1) begin
                r_pend1  <= 1'b1;
                r_wr1    <= c1_wr_en;
                r_addr1  <= c1_addr;
                r_wdata1 <= c1_wdata;
            end

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_rd_we) begin
                r_line[BEATW*r_cnt +: BEATW] <= bus_rdata;
            end

            if (w_to_abort) begin
                r_to <= 1'b1;
            end else if (r_state == c_RESP) begin
                r_to <= 1'b0;
            end

            r_c0_dv <= 1'b0;
            r_c1_dv <= 1'b0;
            r_err   <= 1'b0;
            if (r_state == c_RESP) begin
                r_err  <= r_to;
                r_last <= r_gnt;
                if (r_gnt) begin
                    r_c1_dv <= 1'b1;
                    r_pend1 <= 1'b0;
                    if (!r_wr1) begin
                        r_c1_rdata <= r_to ? '0 : r_line;
                    end
                end else begin
                    r_c0_dv <= 1'b1;
                    r_pend0 <= 1'b0;
                    if (!r_wr0) begin
                        r_c0_rdata <= r_to ? '0 : r_line;
                    end
                end
            end
        end
    end

    assign bus_req       = w_bus_req;
    assign bus_wr        = w_bus_req & w_cur_wr;
    assign bus_addr      = w_bus_req ? (w_cur_addr & c_ADDR_MASK) : '0;
    assign bus_wvalid    = w_bus_wvalid;
    assign bus_wdata     = w_bus_wvalid ? w_cur_wdata[BEATW*r_cnt +: BEATW] : '0;
    assign c0_rdata      = r_c0_rdata;
    assign c1_rdata      = r_c1_rdata;
    assign c0_data_valid = r_c0_dv;
    assign c1_data_valid = r_c1_dv;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Memory-side responder for the cache line-fill/write-back interface; serves two cache clients, 0 = instruction cache and 1 = data cache.
- Accepts whole-line read and write requests and arbitrates between the clients round-robin.
- Serialises each line into 64-bit beats on a single downstream memory bus.
- Returns the assembled 512-bit line, or a write completion, to the requesting cache with a one-cycle data_valid pulse.

Parameters:
BLOCKSZ, 512, cache line width in bits
BEATW, 64, downstream bus data width in bits; BLOCKSZ/BEATW = beats per line (default 8)
ADDRESSSIZE, 64, address width
TIMEOUT_CYCLES, 256, beat watchdog limit (only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset
c0_req  in  1  client 0 request strobe
c0_wr_en  in  1  client 0: 1 = line write-back, 0 = line fill
c0_addr  in  ADDRESSSIZE  client 0 line address
c0_wdata  in  BLOCKSZ  client 0 write line
c0_rdata  out  BLOCKSZ  client 0 returned line
c0_data_valid  out  1  client 0 completion pulse
c1_req, c1_wr_en, c1_addr, c1_wdata, c1_rdata, c1_data_valid: same as client 0, for client 1
bus_req  out  1  downstream command valid
bus_wr  out  1  downstream command is write
bus_addr  out  ADDRESSSIZE  downstream line address, low 6 bits zero
bus_ack  in  1  command accepted
bus_wdata  out  BEATW  write beat
bus_wvalid  out  1  write beat valid
bus_wready  in  1  write beat accepted
bus_rdata  in  BEATW  read beat
bus_rvalid  in  1  read beat valid
err  out  1  timeout abort flag, coincident with data_valid

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, rdata 0, state IDLE, pending flags clear, round-robin pointer = client 0.
- Request capture:
  - A cycle with cN_req = 1 sets pending_N and latches wr_en, addr and wdata.
  - Capture occurs in any state.
  - A second req from the same client while pending_N is set, or while client N is being served, is ignored. The first request wins.
- State IDLE:
  - If one pending flag is set, grant that client.
  - If both are set, grant the client opposite to the last-served client.
  - Go to CMD. Grant is earliest in the cycle after req.
- State CMD:
  - Drive bus_req = 1, bus_wr = latched wr_en, bus_addr = addr & ~63.
  - Hold until bus_ack.
  - On ack, go to RD_BEATS if read, else WR_BEATS. The beat counter clears to 0.
- State RD_BEATS:
  - Each bus_rvalid writes bus_rdata into line bits [BEATW*cnt +: BEATW] and increments cnt.
  - On the beat with cnt = last, go to RESP.
- State WR_BEATS:
  - bus_wvalid = 1 and bus_wdata = wdata[BEATW*cnt +: BEATW].
  - cnt increments on bus_wvalid & bus_wready.
  - The last accepted beat goes to RESP.
- State RESP:
  - cN_data_valid = 1 for exactly one cycle.
  - For reads, cN_rdata holds the assembled line and stays stable until that client's next RESP.
  - Clear pending_N, record last-served = N, go to IDLE.
- Latency: an uncontended read with bus_ack and rvalid every cycle completes req -> data_valid in 12 cycles:
  - 1 cycle capture
  - 1 cycle CMD
  - 8 cycles of beats
  - 1 cycle RESP
  - 1 cycle registered output
- Stray inputs: bus_rvalid outside RD_BEATS and bus_wready outside WR_BEATS are ignored.
- Simultaneous c0_req and c1_req in IDLE: the client opposite to the last-served client wins. After reset that is client 1, because last-served = 0.
- Reset mid-operation: the transaction is aborted, no data_valid is issued, and all pending requests are discarded.

Optional Feature:
ARB_TIMEOUT_EN:
- When defined: a counter runs in CMD, RD_BEATS and WR_BEATS and resets on each ack or beat.
- On reaching TIMEOUT_CYCLES, go to RESP with err = 1. For reads, cN_rdata is driven to all zeros.
- When undefined: err is tied to 0 and the block waits indefinitely.

Test Plan:
- Read on c0, addr 0x1234_5678 -> bus_addr 0x1234_5640; 8 rvalid beats 0x0..0x7 in consecutive cycles -> c0_rdata beat i = i, c0_data_valid high 1 cycle, 12 cycles after req.
- Write on c1, wdata beat i = 0xA0+i, bus_wready low on alternate cycles -> bus_wdata sequence 0xA0..0xA7 with no repeat or skip, c1_data_valid once after the 8th acceptance.
- c0_req and c1_req asserted in the same cycle after reset -> c1 served first, then c0; a following double request -> c0 first (alternation).
- c0 requests again while its read is in flight, with a different addr -> second request ignored, single data_valid, rdata for the first address.
- rst asserted during beat 4 of a read -> no data_valid, bus_req 0 the next cycle, and a new read afterwards completes normally.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, bus_ack never asserted -> c0_data_valid and err high together after 16 cycles, rdata 0.
